// File: rtl/kahn_topo_sorter.sv
// Kahn's-algorithm topological sorter: builds an indegree table from the edge stream,
// sweeps it for roots, then walks successors via the adjacency query/reply port.
module kahn_topo_sorter #(
   parameter int MAX_NODES  = 1024,
   parameter int MAX_EDGES  = 2048,
   parameter int NODE_WIDTH = $clog2(MAX_NODES),
   parameter int DEG_WIDTH  = $clog2(MAX_EDGES + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  edge_valid,
   input  logic [NODE_WIDTH-1:0] src_node,
   input  logic [NODE_WIDTH-1:0] dst_node,
   input  logic                  decoding_done,
   input  logic [NODE_WIDTH:0]   node_count,
   output logic                  query_valid,
   input  logic                  query_ready,
   output logic [NODE_WIDTH-1:0] query_data,
   input  logic                  reply_valid,
   output logic                  reply_ready,
   input  logic [NODE_WIDTH-1:0] reply_data,
   input  logic                  reply_last,
   input  logic                  reply_none,
   output logic                  sorted_valid,
   input  logic                  sorted_ready,
   output logic [NODE_WIDTH-1:0] sorted_node,
   output logic                  sorted_last,
   output logic                  done,
   output logic                  cycle_error,
   output logic                  overflow_error,
   output logic                  underflow_error
);

   // state   | meaning
   // CLEAR   | zero the indegree RAM, one address per cycle
   // COLLECT | count indegrees from the edge stream, then drain the RMW pipe
   // SWEEP   | scan indeg[0..node_count-1], queue every zero
   // POP     | take the next ready node from the FIFO (empty -> FINISH)
   // EMIT    | present the current node on the sorted port
   // QUERY   | request successors of the current node
   // DRAIN   | decrement successor indegrees, queue new zeros
   // FINISH  | report done / cycle_error until reset
   typedef enum logic [2:0] {
      S_CLEAR, S_COLLECT, S_SWEEP, S_POP, S_EMIT, S_QUERY, S_DRAIN, S_FINISH
   } state_t;

   localparam logic [DEG_WIDTH-1:0]  DEG_MAX    = '1;
   localparam logic [DEG_WIDTH-1:0]  DEG_ONE    = DEG_WIDTH'(1);
   localparam logic [DEG_WIDTH-1:0]  EDGE_LIMIT = DEG_WIDTH'(MAX_EDGES);
   localparam logic [NODE_WIDTH-1:0] LAST_IDX   = NODE_WIDTH'(MAX_NODES - 1);

   logic [DEG_WIDTH-1:0]  indeg_mem [MAX_NODES];
   logic [NODE_WIDTH-1:0] fifo_mem  [MAX_NODES];

   state_t                state_q, state_d;
   logic [NODE_WIDTH-1:0] clr_addr_q, clr_addr_d;
   logic [NODE_WIDTH:0]   node_cnt_q, node_cnt_d;
   logic [NODE_WIDTH:0]   emitted_q, emitted_d;
   logic [DEG_WIDTH-1:0]  edge_cnt_q, edge_cnt_d;
   logic                  done_seen_q, done_seen_d;
   logic [1:0]            wait_q, wait_d;
   logic [NODE_WIDTH:0]   sweep_addr_q, sweep_addr_d;
   logic                  sw_valid_q, sw_valid_d;
   logic [NODE_WIDTH-1:0] sw_addr_q, sw_addr_d;
   logic [NODE_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [NODE_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [NODE_WIDTH:0]   fifo_cnt_q, fifo_cnt_d;
   logic [NODE_WIDTH-1:0] cur_q, cur_d;
   logic                  last_seen_q, last_seen_d;
   logic                  s1_valid_q, s1_valid_d;
   logic                  s1_inc_q, s1_inc_d;
   logic [NODE_WIDTH-1:0] s1_addr_q, s1_addr_d;
   logic                  wb_valid_q, wb_valid_d;
   logic [NODE_WIDTH-1:0] wb_addr_q, wb_addr_d;
   logic [DEG_WIDTH-1:0]  wb_data_q, wb_data_d;
   logic                  query_valid_q, query_valid_d;
   logic [NODE_WIDTH-1:0] query_data_q, query_data_d;
   logic                  reply_ready_q, reply_ready_d;
   logic                  sorted_valid_q, sorted_valid_d;
   logic [NODE_WIDTH-1:0] sorted_node_q, sorted_node_d;
   logic                  sorted_last_q, sorted_last_d;
   logic                  done_q, done_d;
   logic                  cycle_err_q, cycle_err_d;
   logic                  ovf_err_q, ovf_err_d;
   logic                  unf_err_q, unf_err_d;

   logic [DEG_WIDTH-1:0]  rd_data_q;
   logic [NODE_WIDTH-1:0] rd_addr;
   logic                  mem_we;
   logic [NODE_WIDTH-1:0] mem_waddr;
   logic [DEG_WIDTH-1:0]  mem_wdata;
   logic [DEG_WIDTH-1:0]  old_val;
   logic                  rmw_issue, rmw_inc;
   logic [NODE_WIDTH-1:0] rmw_addr;
   logic                  push, pop;
   logic [NODE_WIDTH-1:0] push_data;
   logic [NODE_WIDTH-1:0] fifo_head;
   logic                  unused_src;

   assign unused_src = ^src_node;
   assign fifo_head  = fifo_mem[rd_ptr_q];

   // The RAM read issued alongside last cycle's write misses it; forward that write.
   assign old_val = (wb_valid_q && wb_addr_q == s1_addr_q) ? wb_data_q : rd_data_q;

   always_comb begin
      state_d        = state_q;
      clr_addr_d     = clr_addr_q;
      node_cnt_d     = node_cnt_q;
      emitted_d      = emitted_q;
      edge_cnt_d     = edge_cnt_q;
      done_seen_d    = done_seen_q;
      wait_d         = wait_q;
      sweep_addr_d   = sweep_addr_q;
      sw_valid_d     = 1'b0;
      sw_addr_d      = sw_addr_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      fifo_cnt_d     = fifo_cnt_q;
      cur_d          = cur_q;
      last_seen_d    = last_seen_q;
      query_valid_d  = query_valid_q;
      query_data_d   = query_data_q;
      reply_ready_d  = reply_ready_q;
      sorted_valid_d = sorted_valid_q;
      sorted_node_d  = sorted_node_q;
      sorted_last_d  = sorted_last_q;
      done_d         = done_q;
      cycle_err_d    = cycle_err_q;
      ovf_err_d      = ovf_err_q;
      unf_err_d      = unf_err_q;
      rd_addr        = '0;
      mem_we         = 1'b0;
      mem_waddr      = s1_addr_q;
      mem_wdata      = '0;
      rmw_issue      = 1'b0;
      rmw_inc        = 1'b0;
      rmw_addr       = '0;
      push           = 1'b0;
      push_data      = '0;
      pop            = 1'b0;

      if (s1_valid_q) begin
         mem_we = 1'b1;
         if (s1_inc_q) begin
            if (old_val == DEG_MAX) begin
               mem_wdata = old_val;
               ovf_err_d = 1'b1;
            end else begin
               mem_wdata = old_val + 1'b1;
            end
         end else if (old_val == '0) begin
            mem_wdata = '0;
            unf_err_d = 1'b1;
         end else begin
            mem_wdata = old_val - 1'b1;
            if (old_val == DEG_ONE) begin
               push      = 1'b1;
               push_data = s1_addr_q;
            end
         end
      end
      wb_valid_d = s1_valid_q;
      wb_addr_d  = s1_addr_q;
      wb_data_d  = mem_wdata;

      case (state_q)
         S_CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr_q;
            mem_wdata = '0;
            if (clr_addr_q == LAST_IDX) state_d = S_COLLECT;
            else                        clr_addr_d = clr_addr_q + 1'b1;
         end
         S_COLLECT: begin
            if (!done_seen_q) begin
               if (edge_valid) begin
                  if (edge_cnt_q == EDGE_LIMIT) begin
                     ovf_err_d = 1'b1;
                  end else begin
                     edge_cnt_d = edge_cnt_q + 1'b1;
                     rmw_issue  = 1'b1;
                     rmw_inc    = 1'b1;
                     rmw_addr   = dst_node;
                     rd_addr    = dst_node;
                  end
               end
               if (decoding_done) begin
                  done_seen_d = 1'b1;
                  node_cnt_d  = node_count;
                  wait_d      = 2'd2;
               end
            end else if (wait_q == 2'd1) begin
               state_d      = S_SWEEP;
               sweep_addr_d = '0;
            end else begin
               wait_d = wait_q - 1'b1;
            end
         end
         S_SWEEP: begin
            if (node_cnt_q == '0) begin
               state_d = S_FINISH;
            end else begin
               if (sweep_addr_q < node_cnt_q) begin
                  rd_addr      = sweep_addr_q[NODE_WIDTH-1:0];
                  sw_valid_d   = 1'b1;
                  sw_addr_d    = sweep_addr_q[NODE_WIDTH-1:0];
                  sweep_addr_d = sweep_addr_q + 1'b1;
               end else if (!sw_valid_q) begin
                  state_d = S_POP;
               end
               if (sw_valid_q && rd_data_q == '0) begin
                  push      = 1'b1;
                  push_data = sw_addr_q;
               end
            end
         end
         S_POP: begin
            if (fifo_cnt_q == '0) begin
               state_d = S_FINISH;
            end else begin
               pop            = 1'b1;
               cur_d          = fifo_head;
               sorted_valid_d = 1'b1;
               sorted_node_d  = fifo_head;
               sorted_last_d  = (emitted_q + 1'b1 == node_cnt_q);
               state_d        = S_EMIT;
            end
         end
         S_EMIT: begin
            if (sorted_ready) begin
               sorted_valid_d = 1'b0;
               sorted_last_d  = 1'b0;
               emitted_d      = emitted_q + 1'b1;
               query_valid_d  = 1'b1;
               query_data_d   = cur_q;
               state_d        = S_QUERY;
            end
         end
         S_QUERY: begin
            if (query_ready) begin
               query_valid_d = 1'b0;
               reply_ready_d = 1'b1;
               last_seen_d   = 1'b0;
               state_d       = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (reply_ready_q && reply_valid) begin
               if (!reply_none) begin
                  rmw_issue = 1'b1;
                  rmw_addr  = reply_data;
                  rd_addr   = reply_data;
               end
               if (reply_last) begin
                  reply_ready_d = 1'b0;
                  last_seen_d   = 1'b1;
               end
            end
            if (last_seen_q && !s1_valid_q) state_d = S_POP;
         end
         S_FINISH: begin
            done_d = 1'b1;
            if (emitted_q != node_cnt_q) cycle_err_d = 1'b1;
         end
         default: state_d = S_CLEAR;
      endcase

      // Each node is pushed at most once and pops happen only in POP, so no collision.
      if (push) begin
         wr_ptr_d   = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
         fifo_cnt_d = fifo_cnt_d + 1'b1;
      end
      if (pop) begin
         rd_ptr_d   = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
         fifo_cnt_d = fifo_cnt_d - 1'b1;
      end

      s1_valid_d = rmw_issue;
      s1_inc_d   = rmw_inc;
      s1_addr_d  = rmw_addr;
   end

   always_ff @(posedge clk) begin
      if (mem_we) indeg_mem[mem_waddr] <= mem_wdata;
      rd_data_q <= indeg_mem[rd_addr];
      if (push) fifo_mem[wr_ptr_q] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_CLEAR;
         clr_addr_q     <= '0;
         node_cnt_q     <= '0;
         emitted_q      <= '0;
         edge_cnt_q     <= '0;
         done_seen_q    <= 1'b0;
         wait_q         <= '0;
         sweep_addr_q   <= '0;
         sw_valid_q     <= 1'b0;
         sw_addr_q      <= '0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         fifo_cnt_q     <= '0;
         cur_q          <= '0;
         last_seen_q    <= 1'b0;
         s1_valid_q     <= 1'b0;
         s1_inc_q       <= 1'b0;
         s1_addr_q      <= '0;
         wb_valid_q     <= 1'b0;
         wb_addr_q      <= '0;
         wb_data_q      <= '0;
         query_valid_q  <= 1'b0;
         query_data_q   <= '0;
         reply_ready_q  <= 1'b0;
         sorted_valid_q <= 1'b0;
         sorted_node_q  <= '0;
         sorted_last_q  <= 1'b0;
         done_q         <= 1'b0;
         cycle_err_q    <= 1'b0;
         ovf_err_q      <= 1'b0;
         unf_err_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         clr_addr_q     <= clr_addr_d;
         node_cnt_q     <= node_cnt_d;
         emitted_q      <= emitted_d;
         edge_cnt_q     <= edge_cnt_d;
         done_seen_q    <= done_seen_d;
         wait_q         <= wait_d;
         sweep_addr_q   <= sweep_addr_d;
         sw_valid_q     <= sw_valid_d;
         sw_addr_q      <= sw_addr_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         fifo_cnt_q     <= fifo_cnt_d;
         cur_q          <= cur_d;
         last_seen_q    <= last_seen_d;
         s1_valid_q     <= s1_valid_d;
         s1_inc_q       <= s1_inc_d;
         s1_addr_q      <= s1_addr_d;
         wb_valid_q     <= wb_valid_d;
         wb_addr_q      <= wb_addr_d;
         wb_data_q      <= wb_data_d;
         query_valid_q  <= query_valid_d;
         query_data_q   <= query_data_d;
         reply_ready_q  <= reply_ready_d;
         sorted_valid_q <= sorted_valid_d;
         sorted_node_q  <= sorted_node_d;
         sorted_last_q  <= sorted_last_d;
         done_q         <= done_d;
         cycle_err_q    <= cycle_err_d;
         ovf_err_q      <= ovf_err_d;
         unf_err_q      <= unf_err_d;
      end
   end

   assign query_valid     = query_valid_q;
   assign query_data      = query_data_q;
   assign reply_ready     = reply_ready_q;
   assign sorted_valid    = sorted_valid_q;
   assign sorted_node     = sorted_node_q;
   assign sorted_last     = sorted_last_q;
   assign done            = done_q;
   assign cycle_error     = cycle_err_q;
   assign overflow_error  = ovf_err_q;
   assign underflow_error = unf_err_q;

endmodule
